// File: rtl/pipe_reg_pkg.sv
// Shared constants and types for the pipelined register file and its scoreboard.
package pipe_reg_pkg;

    localparam int unsigned REG_ADDR_W = 4;

    // All-ones index: "no register"
    localparam logic [REG_ADDR_W-1:0] RNONE = 4'hF;

    // Architectural register indices
    localparam logic [REG_ADDR_W-1:0] RAX = 4'd0;
    localparam logic [REG_ADDR_W-1:0] RCX = 4'd1;
    localparam logic [REG_ADDR_W-1:0] RDX = 4'd2;
    localparam logic [REG_ADDR_W-1:0] RBX = 4'd3;
    localparam logic [REG_ADDR_W-1:0] RSP = 4'd4;
    localparam logic [REG_ADDR_W-1:0] RBP = 4'd5;
    localparam logic [REG_ADDR_W-1:0] RSI = 4'd6;
    localparam logic [REG_ADDR_W-1:0] RDI = 4'd7;
    localparam logic [REG_ADDR_W-1:0] R8  = 4'd8;
    localparam logic [REG_ADDR_W-1:0] R9  = 4'd9;
    localparam logic [REG_ADDR_W-1:0] R10 = 4'd10;
    localparam logic [REG_ADDR_W-1:0] R11 = 4'd11;
    localparam logic [REG_ADDR_W-1:0] R12 = 4'd12;
    localparam logic [REG_ADDR_W-1:0] R13 = 4'd13;
    localparam logic [REG_ADDR_W-1:0] R14 = 4'd14;

    // Per-register count of outstanding (issued, not yet retired) writes
    localparam int unsigned PEND_W = 2;
    typedef logic [PEND_W-1:0] pend_cnt_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: per-register outstanding-write counters,
// read-port hazard flags and a sticky overflow/underflow error.
// Optional feature: REGFILE_BYPASS_EN suppresses hazards that this
// cycle's writes are about to clear.
module reg_scoreboard
    import pipe_reg_pkg::*;
#(
    parameter int unsigned NREGS  = 15,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dstE,
    input  logic [ADDR_W-1:0] iss_dstM,
    output logic              hazA,
    output logic              hazB,
    output logic              sb_err
);

    pend_cnt_t         cnt     [NREGS];
    pend_cnt_t         cnt_nxt [NREGS];
    logic signed [3:0] net     [NREGS];
    logic              err_nxt;

    // Net counter update per register with saturation at 0 and 3
    always_comb begin
        err_nxt = 1'b0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            net[i] = 4'(cnt[i])
                   + 4'(iss_valid && (iss_dstE == ADDR_W'(i)))
                   + 4'(iss_valid && (iss_dstM == ADDR_W'(i)))
                   - 4'(dstE == ADDR_W'(i))
                   - 4'(dstM == ADDR_W'(i));
            cnt_nxt[i] = net[i][1:0];
            if (net[i] > 4'sd3) begin
                cnt_nxt[i] = 2'd3;
                err_nxt    = 1'b1;
            end else if (net[i] < 4'sd0) begin
                cnt_nxt[i] = 2'd0;
                err_nxt    = 1'b1;
            end
        end
    end

    // Counter and sticky error state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                cnt[i] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            if (err_nxt) begin
                sb_err <= 1'b1;
            end
        end
    end

    // Hazard lookup; RNONE and out-of-range indices never match a counter
    always_comb begin
        hazA = 1'b0;
        hazB = 1'b0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (srcA == ADDR_W'(i)) begin
                hazA = (cnt[i] != '0);
`ifdef REGFILE_BYPASS_EN
                if ((cnt[i] == pend_cnt_t'(1)) && ((dstE == srcA) || (dstM == srcA))) begin
                    hazA = 1'b0;
                end
`endif
            end
            if (srcB == ADDR_W'(i)) begin
                hazB = (cnt[i] != '0);
`ifdef REGFILE_BYPASS_EN
                if ((cnt[i] == pend_cnt_t'(1)) && ((dstE == srcB) || (dstM == srcB))) begin
                    hazB = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/pipe_reg_file.sv
// Pipelined register file: two combinational read ports, two write ports
// (M wins on collision), stack pointer with non-zero reset value, and a
// pending-write scoreboard.
// Optional feature: REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module pipe_reg_file
    import pipe_reg_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NREGS    = 15,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned SP_IDX   = 4,
    parameter int unsigned SP_RESET = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dstE,
    input  logic [ADDR_W-1:0] iss_dstM,
    output logic              hazA,
    output logic              hazB,
    output logic              sb_err
);

    logic [DATA_W-1:0] regs [NREGS];

    // Register storage; out-of-range indices (incl. RNONE) match no entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (dstM == ADDR_W'(i)) begin
                    regs[i] <= valM;
                end else if (dstE == ADDR_W'(i)) begin
                    regs[i] <= valE;
                end
            end
        end
    end

    // Read muxes; unmatched indices read as zero
    always_comb begin
        valA = '0;
        valB = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (srcA == ADDR_W'(i)) begin
                valA = regs[i];
            end
            if (srcB == ADDR_W'(i)) begin
                valB = regs[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (srcA < ADDR_W'(NREGS)) begin
            if (srcA == dstM) begin
                valA = valM;
            end else if (srcA == dstE) begin
                valA = valE;
            end
        end
        if (srcB < ADDR_W'(NREGS)) begin
            if (srcB == dstM) begin
                valB = valM;
            end else if (srcB == dstE) begin
                valB = valE;
            end
        end
`endif
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .srcA      (srcA),
        .srcB      (srcB),
        .dstE      (dstE),
        .dstM      (dstM),
        .iss_valid (iss_valid),
        .iss_dstE  (iss_dstE),
        .iss_dstM  (iss_dstM),
        .hazA      (hazA),
        .hazB      (hazB),
        .sb_err    (sb_err)
    );

endmodule

// File: tb/tb_pipe_reg_file.sv
// Self-checking bench for pipe_reg_file: directed stimulus pushes expected
// read/hazard/error values into a queue; a negedge monitor pops and compares.
module tb_pipe_reg_file;
    import pipe_reg_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  srcA, srcB, dstE, dstM, iss_dstE, iss_dstM;
    logic [63:0] valA, valB, valE, valM;
    logic        iss_valid, hazA, hazB, sb_err;

    typedef struct {
        string       name;
        logic [63:0] ea;
        logic [63:0] eb;
        logic        eha;
        logic        ehb;
        logic        eerr;
    } exp_t;

    exp_t        expq [$];
    logic        sample = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] m [15];

    pipe_reg_file dut (
        .clk       (clk),
        .rst       (rst),
        .srcA      (srcA),
        .srcB      (srcB),
        .valA      (valA),
        .valB      (valB),
        .dstE      (dstE),
        .dstM      (dstM),
        .valE      (valE),
        .valM      (valM),
        .iss_valid (iss_valid),
        .iss_dstE  (iss_dstE),
        .iss_dstM  (iss_dstM),
        .hazA      (hazA),
        .hazB      (hazB),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (sample) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL monitor: sample requested with empty queue");
            end else begin
                e = expq.pop_front();
                cmp(e.name, "valA", valA, e.ea);
                cmp(e.name, "valB", valB, e.eb);
                cmp(e.name, "hazA", 64'(hazA), 64'(e.eha));
                cmp(e.name, "hazB", 64'(hazB), 64'(e.ehb));
                cmp(e.name, "sb_err", 64'(sb_err), 64'(e.eerr));
            end
        end
    end

    task automatic idle();
        iss_valid = 1'b0;
        iss_dstE  = RNONE;
        iss_dstM  = RNONE;
        dstE      = RNONE;
        dstM      = RNONE;
        valE      = '0;
        valM      = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present read indices, queue the expectation, consume one clock edge
    task automatic check(input string nm, input logic [3:0] a, input logic [3:0] b,
                         input logic [63:0] ea, input logic [63:0] eb,
                         input logic eha, input logic ehb, input logic eerr);
        exp_t e;
        srcA   = a;
        srcB   = b;
        e.name = nm;
        e.ea   = ea;
        e.eb   = eb;
        e.eha  = eha;
        e.ehb  = ehb;
        e.eerr = eerr;
        expq.push_back(e);
        sample = 1'b1;
        @(posedge clk);
        #1;
        sample = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) begin
            m[i] = (i == 4) ? 64'd50 : 64'd0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        srcA = RAX;
        srcB = RAX;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state, sampled while rst is still high
        check("rst_hold", RSP, RAX, 64'd50, 64'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("reset_val", 4'(i), 4'(14 - i), m[i], m[14 - i], 1'b0, 1'b0, 1'b0);
        end
        check("rnone_rd", RNONE, RNONE, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);

        // Same register on both issue ports counts twice
        iss_valid = 1'b1; iss_dstE = RDX; iss_dstM = RDX;
        step(); idle();
        check("dual_issue", RDX, RAX, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Write collision: M wins; both retires clear the count of 2
        dstE = RDX; dstM = RDX; valE = 64'd7; valM = 64'd9;
        check("collide_pre", RDX, RAX, BYP ? 64'd9 : 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        idle(); m[2] = 64'd9;
        for (int i = 0; i < 15; i++) begin
            check("collide_post", 4'(i), 4'(i), m[i], m[i], 1'b0, 1'b0, 1'b0);
        end

        // Issue then retire on RBX
        iss_valid = 1'b1; iss_dstE = RBX;
        step(); idle();
        check("flow_haz", RBX, RBX, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0);
        dstE = RBX; valE = 64'h55;
        check("flow_retire_pre", RBX, RAX, BYP ? 64'h55 : 64'd0, 64'd0, BYP ? 1'b0 : 1'b1, 1'b0, 1'b0);
        idle(); m[3] = 64'h55;
        check("flow_done", RBX, RAX, 64'h55, 64'd0, 1'b0, 1'b0, 1'b0);

        // Simultaneous issue and retire nets out
        iss_valid = 1'b1; iss_dstE = RSI;
        step(); idle();
        iss_valid = 1'b1; iss_dstE = RSI; dstE = RSI; valE = 64'h11;
        step(); idle(); m[6] = 64'h11;
        check("net_hold", RSI, RSI, 64'h11, 64'h11, 1'b1, 1'b1, 1'b0);
        dstM = RSI; valM = 64'h22;
        step(); idle(); m[6] = 64'h22;
        check("net_done", RSI, RAX, 64'h22, 64'd0, 1'b0, 1'b0, 1'b0);

        // Same-cycle read of a register being written
        iss_valid = 1'b1; iss_dstM = RCX;
        step(); idle();
        dstM = RCX; valM = 64'hABCD;
        check("byp_pre", RCX, RCX, BYP ? 64'hABCD : 64'd0, BYP ? 64'hABCD : 64'd0,
              BYP ? 1'b0 : 1'b1, BYP ? 1'b0 : 1'b1, 1'b0);
        idle(); m[1] = 64'hABCD;
        check("byp_post", RCX, RAX, 64'hABCD, 64'd0, 1'b0, 1'b0, 1'b0);

        // RNONE writes are ignored and RNONE reads as zero
        dstE = RNONE; valE = 64'd1; dstM = RNONE; valM = 64'd2;
        check("oor_pre", RNONE, RAX, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 15; i++) begin
            check("oor_post", 4'(i), RNONE, m[i], 64'd0, 1'b0, 1'b0, 1'b0);
        end

        // Four issues to RBP: saturate at 3 and set sticky error
        for (int k = 0; k < 4; k++) begin
            iss_valid = 1'b1; iss_dstE = RBP;
            step(); idle();
            check("ovf_issue", RBP, RAX, m[5], 64'd0, 1'b1, 1'b0, (k == 3) ? 1'b1 : 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            dstE = RBP; valE = 64'h100 + 64'(k);
            step(); idle(); m[5] = 64'h100 + 64'(k);
            check("ovf_retire", RBP, RAX, m[5], 64'd0, (k < 2) ? 1'b1 : 1'b0, 1'b0, 1'b1);
        end

        // Async reset between edges takes effect without a clock edge
        rst = 1'b1;
        model_reset();
        check("async_rst", RBP, RSP, 64'd0, 64'd50, 1'b0, 1'b0, 1'b0);

        // Writes and issues while in reset are discarded
        dstE = RBX; valE = 64'h77; iss_valid = 1'b1; iss_dstE = RBX;
        step();
        idle();
        rst = 1'b0;
        check("post_rst_a", RBX, RSP, 64'd0, 64'd50, 1'b0, 1'b0, 1'b0);
        check("post_rst_b", RCX, RDX, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);

        step();
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", expq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_reg_file.md
PIPE_REG_FILE -- requirements
Module: pipe_reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register data width.
REQ-002 SHALL have parameter NREGS, default 15, number of architectural registers, maximum 2^ADDR_W-1.
REQ-003 SHALL have parameter ADDR_W, default 4, register index width; index all-ones (RNONE) means "no register".
REQ-004 SHALL have parameter SP_IDX, default 4, stack-pointer index.
REQ-005 SHALL have parameter SP_RESET, default 50, stack-pointer reset value.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-008 SHALL have ports srcA, srcB  input  ADDR_W  read-port indices.
REQ-009 SHALL have ports valA, valB  output  DATA_W  read data, combinational.
REQ-010 SHALL have ports dstE, dstM  input  ADDR_W  write-port indices; RNONE means no write.
REQ-011 SHALL have ports valE, valM  input  DATA_W  write data.
REQ-012 SHALL have ports iss_valid (input, 1), iss_dstE and iss_dstM (input, ADDR_W); together they declare an instruction issuing future writes.
REQ-013 SHALL have ports hazA, hazB  output  1  srcA/srcB has an outstanding write.
REQ-014 SHALL have port sb_err  output  1  sticky scoreboard overflow/underflow flag.

Function
REQ-015 A write SHALL take effect at the rising clk edge when its index is below NREGS; an index >= NREGS, including RNONE, SHALL be ignored.
REQ-016 When dstE==dstM (not RNONE), the M port SHALL win and valM SHALL be stored.
REQ-017 A read of RNONE or of an index >= NREGS SHALL return 0.
REQ-018 Each register SHALL have a 2-bit pending counter:
- incremented on a cycle with iss_valid=1 for each of iss_dstE/iss_dstM that matches the register;
- decremented once for each of dstE/dstM that matches it.
REQ-019 When iss_dstE==iss_dstM, the counter SHALL increment by 2.
REQ-020 A simultaneous increment and decrement on the same register SHALL net out; for example, counter 1 with one issue and one retire stays 1.
REQ-021 On overflow (a result above 3) or underflow (a decrement below 0), the counter SHALL saturate, and sb_err SHALL set and remain set until reset.
REQ-022 hazA SHALL be 1 when counter[srcA] is nonzero and srcA is not RNONE; hazB is the same for srcB.
REQ-023 Read latency SHALL be 0 cycles; write-to-read visibility SHALL be 1 cycle, except as in REQ-027.

Reset
REQ-024 While rst is high, all registers SHALL be 0 except register SP_IDX, which SHALL be SP_RESET.
REQ-025 While rst is high, all pending counters and sb_err SHALL be 0, so hazA=hazB=0; valA/valB reflect the reset contents.
REQ-026 Reset asserted mid-operation SHALL discard same-edge writes and issues; the first update occurs on the first rising edge after rst deasserts.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, the block SHALL forward same-cycle write data to the read ports:
- valA = valM if srcA==dstM; else valE if srcA==dstE; else the stored value. valB behaves the same way.
- hazA/hazB SHALL be suppressed when this cycle's writes retire the last outstanding write to that index (counter==1 and matching dst).
REQ-028 Without REGFILE_BYPASS_EN, reads SHALL return stored values only, and haz* SHALL reflect the counter alone.

Structure
REQ-029 Package pipe_reg_pkg SHALL hold:
- the RNONE constant;
- named register-index constants (RAX=0, RCX=1, RDX=2, RBX=3, RSP=4, RBP=5, RSI=6, RDI=7, R8..R14=8..14);
- the pending-counter typedef.
REQ-030 The scoreboard (pending counters, haz logic, sb_err) SHALL be sub-module reg_scoreboard; storage and read muxing SHALL stay in pipe_reg_file.

Verification
REQ-031 Reset: pulse rst -> reg 4 reads 50, regs 0-3 and 5-14 read 0, hazA=hazB=0, sb_err=0.
REQ-032 Dual-write collision: dstE=dstM=2, valE=7, valM=9, one edge -> reg 2 reads 9 and no other register changes.
REQ-033 Scoreboard flow:
- iss_valid=1, iss_dstE=3 -> next cycle hazA=1 with srcA=3;
- dstE=3, valE=0x55 for one edge -> hazA=0 and valA=0x55.
REQ-034 Bypass (REGFILE_BYPASS_EN defined): srcA=1, dstM=1, valM=0xABCD in the same cycle -> valA=0xABCD before the edge; without the macro, valA shows the old value until after the edge.
REQ-035 Overflow: four issues to reg 5 without retire -> sb_err=1 after the 4th edge and the counter holds 3; sb_err stays set after retires, clears only on rst.
REQ-036 Out-of-range and async reset: write dstE=15 (RNONE) valE=1 -> no register changes and reads of 15 return 0; assert rst between edges -> contents reset immediately without waiting for a clk edge.
